fifo_track_tap: RTL and testbench

Monitor-side front end for the tracking checker. Taps the write and read sides of a design FIFO and extracts a label field from each pushed/popped word. Emits insert events (mark=1 on push) and remove events (mark=0 on pop) as a single serial stream into one tracking input port (track_label/track_mark/track_fifo_we). An internal event queue absorbs dual events per cycle and honours the checker's track_fifo_full back-pressure.

---
 rtl/fifo_track_tap.sv | 130 +++++++++++++
 tb/tb_fifo_track_tap.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_track_tap.sv
// Monitor tap: turns design-FIFO push/pop strobes into a serial insert/remove event stream.
// Optional label filter enabled by defining TRACK_TAP_FILTER_EN.
module fifo_track_tap #(
   parameter int unsigned DATAWIDTH  = 32,
   parameter int unsigned LABELWIDTH = 20,
   parameter int unsigned LABELLSB   = 0,
   parameter int unsigned QWIDTH     = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATAWIDTH-1:0]  mon_wr_data,
   input  logic                  mon_we,
   input  logic [DATAWIDTH-1:0]  mon_rd_data,
   input  logic                  mon_re,
`ifdef TRACK_TAP_FILTER_EN
   input  logic [LABELWIDTH-1:0] filter_mask,
   input  logic [LABELWIDTH-1:0] filter_value,
`endif
   output logic [LABELWIDTH-1:0] track_label,
   output logic                  track_mark,
   output logic                  track_fifo_we,
   input  logic                  track_fifo_full,
   input  logic                  clr_overflow,
   output logic                  overflow,
   output logic [15:0]           drop_count,
   output logic [QWIDTH:0]       level
);

   localparam int unsigned DEPTH = 1 << QWIDTH;
   localparam int unsigned EW    = LABELWIDTH + 1;
   localparam int unsigned PW    = QWIDTH + 1;

   logic [EW-1:0]         mem [DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [PW-1:0]         used_c, free_c, wr_ptr_nxt_c, rd_ptr_nxt_c;
   logic [LABELWIDTH-1:0] wr_label_c, rd_label_c;
   logic                  wr_pass_c, rd_pass_c;
   logic                  push_ev_c, pop_ev_c;
   logic                  acc_push_c, acc_pop_c;
   logic [1:0]            n_acc_c, n_drop_c;
   logic [EW-1:0]         first_ev_c;
   logic                  out_pop_c;
   logic [QWIDTH-1:0]     wr_idx0_c, wr_idx1_c;
   logic [16:0]           drop_sum_c;

   assign wr_label_c = mon_wr_data[LABELLSB +: LABELWIDTH];
   assign rd_label_c = mon_rd_data[LABELLSB +: LABELWIDTH];

`ifdef TRACK_TAP_FILTER_EN
   assign wr_pass_c = (wr_label_c & filter_mask) == (filter_value & filter_mask);
   assign rd_pass_c = (rd_label_c & filter_mask) == (filter_value & filter_mask);
`else
   assign wr_pass_c = 1'b1;
   assign rd_pass_c = 1'b1;
`endif

   assign push_ev_c = mon_we & wr_pass_c;
   assign pop_ev_c  = mon_re & rd_pass_c;
   assign used_c    = wr_ptr - rd_ptr;
   assign free_c    = PW'(DEPTH) - used_c;

   // Admission in capture order (push before pop); free space ignores this edge's output pop.
   always_comb begin
      acc_push_c = 1'b0;
      acc_pop_c  = 1'b0;
      n_drop_c   = 2'd0;
      if (push_ev_c && pop_ev_c) begin
         if (free_c >= PW'(2)) begin
            acc_push_c = 1'b1;
            acc_pop_c  = 1'b1;
         end else if (free_c == PW'(1)) begin
            acc_push_c = 1'b1;
            n_drop_c   = 2'd1;
         end else begin
            n_drop_c   = 2'd2;
         end
      end else if (push_ev_c) begin
         if (free_c != '0) acc_push_c = 1'b1;
         else              n_drop_c   = 2'd1;
      end else if (pop_ev_c) begin
         if (free_c != '0) acc_pop_c  = 1'b1;
         else              n_drop_c   = 2'd1;
      end
   end

   assign n_acc_c      = 2'(acc_push_c) + 2'(acc_pop_c);
   assign first_ev_c   = acc_push_c ? {wr_label_c, 1'b1} : {rd_label_c, 1'b0};
   assign wr_idx0_c    = wr_ptr[QWIDTH-1:0];
   assign wr_idx1_c    = wr_ptr[QWIDTH-1:0] + QWIDTH'(1);
   assign out_pop_c    = (used_c != '0) && !track_fifo_full;
   assign wr_ptr_nxt_c = wr_ptr + PW'(n_acc_c);
   assign rd_ptr_nxt_c = rd_ptr + PW'(out_pop_c);
   assign drop_sum_c   = {1'b0, drop_count} + 17'(n_drop_c);

   // Event storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (n_acc_c != 2'd0) mem[wr_idx0_c] <= first_ev_c;
      if (n_acc_c == 2'd2) mem[wr_idx1_c] <= {rd_label_c, 1'b0};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         level         <= '0;
         track_label   <= '0;
         track_mark    <= 1'b0;
         track_fifo_we <= 1'b0;
         overflow      <= 1'b0;
         drop_count    <= '0;
      end else begin
         wr_ptr        <= wr_ptr_nxt_c;
         rd_ptr        <= rd_ptr_nxt_c;
         level         <= wr_ptr_nxt_c - rd_ptr_nxt_c;
         track_fifo_we <= out_pop_c;
         if (out_pop_c) begin
            {track_label, track_mark} <= mem[rd_ptr[QWIDTH-1:0]];
         end
         // A drop on the clearing edge wins over the clear.
         if (clr_overflow) begin
            overflow   <= (n_drop_c != 2'd0);
            drop_count <= 16'(n_drop_c);
         end else if (n_drop_c != 2'd0) begin
            overflow   <= 1'b1;
            drop_count <= drop_sum_c[16] ? 16'hFFFF : drop_sum_c[15:0];
         end
      end
   end

endmodule

// File: tb/tb_fifo_track_tap.sv
// Directed self-checking bench for fifo_track_tap (default build, filter absent unless macro set).
module tb_fifo_track_tap;

   localparam int unsigned DW = 32;
   localparam int unsigned LW = 20;
   localparam int unsigned QW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] mon_wr_data, mon_rd_data;
   logic          mon_we, mon_re;
   logic [LW-1:0] track_label;
   logic          track_mark, track_fifo_we, track_fifo_full, clr_overflow, overflow;
   logic [15:0]   drop_count;
   logic [QW:0]   level;
`ifdef TRACK_TAP_FILTER_EN
   logic [LW-1:0] filter_mask, filter_value;
`endif

   int checks   = 0;
   int failures = 0;

   fifo_track_tap #(.DATAWIDTH(DW), .LABELWIDTH(LW), .LABELLSB(0), .QWIDTH(QW)) dut (
      .clk(clk), .reset(reset),
      .mon_wr_data(mon_wr_data), .mon_we(mon_we),
      .mon_rd_data(mon_rd_data), .mon_re(mon_re),
`ifdef TRACK_TAP_FILTER_EN
      .filter_mask(filter_mask), .filter_value(filter_value),
`endif
      .track_label(track_label), .track_mark(track_mark), .track_fifo_we(track_fifo_we),
      .track_fifo_full(track_fifo_full), .clr_overflow(clr_overflow),
      .overflow(overflow), .drop_count(drop_count), .level(level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_ev(input string tag, input logic [LW-1:0] lbl, input logic mk);
      check({tag, "_we"}, 32'(track_fifo_we), 32'd1);
      check({tag, "_label"}, 32'(track_label), 32'(lbl));
      check({tag, "_mark"}, 32'(track_mark), 32'(mk));
   endtask

   initial begin
      reset = 1'b1; mon_we = 1'b0; mon_re = 1'b0;
      mon_wr_data = '0; mon_rd_data = '0;
      track_fifo_full = 1'b0; clr_overflow = 1'b0;
`ifdef TRACK_TAP_FILTER_EN
      filter_mask = '0; filter_value = '0;
`endif
      tick(); tick();
      check("rst_label", 32'(track_label), 32'd0);
      check("rst_mark", 32'(track_mark), 32'd0);
      reset = 1'b0;

      // Idle after reset
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_we", 32'(track_fifo_we), 32'd0);
         check("idle_level", 32'(level), 32'd0);
         check("idle_ovf", 32'(overflow), 32'd0);
         check("idle_drops", 32'(drop_count), 32'd0);
      end

      // Three consecutive pushes; first output after the second edge
      mon_we = 1'b1; mon_wr_data = 32'h00011;
      tick();
      check("lat_we_early", 32'(track_fifo_we), 32'd0);
      check("lat_level1", 32'(level), 32'd1);
      mon_wr_data = 32'h00021;
      tick();
      expect_ev("push0", 20'h00011, 1'b1);
      mon_wr_data = 32'h00031;
      tick();
      expect_ev("push1", 20'h00021, 1'b1);
      mon_we = 1'b0;
      tick();
      expect_ev("push2", 20'h00031, 1'b1);
      tick();
      check("push_done_we", 32'(track_fifo_we), 32'd0);
      check("push_done_level", 32'(level), 32'd0);

      // Same-cycle push and pop: push ordered first
      mon_we = 1'b1; mon_wr_data = 32'h00061;
      mon_re = 1'b1; mon_rd_data = 32'h00031;
      tick();
      mon_we = 1'b0; mon_re = 1'b0;
      check("dual_level", 32'(level), 32'd2);
      tick();
      expect_ev("dual0", 20'h00061, 1'b1);
      tick();
      expect_ev("dual1", 20'h00031, 1'b0);
      tick();
      check("dual_done_we", 32'(track_fifo_we), 32'd0);

      // Back-pressure: fill all 16 entries
      track_fifo_full = 1'b1;
      mon_we = 1'b1;
      for (int i = 0; i < 16; i++) begin
         mon_wr_data = 32'h00100 + 32'(i);
         tick();
         check("fill_we", 32'(track_fifo_we), 32'd0);
      end
      mon_we = 1'b0;
      check("fill_level", 32'(level), 32'd16);
      check("fill_drops", 32'(drop_count), 32'd0);
      check("fill_ovf", 32'(overflow), 32'd0);

      // Full queue: push+pop both dropped
      mon_we = 1'b1; mon_wr_data = 32'h00AAA;
      mon_re = 1'b1; mon_rd_data = 32'h00BBB;
      tick();
      mon_we = 1'b0; mon_re = 1'b0;
      check("ovf_drops", 32'(drop_count), 32'd2);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_level", 32'(level), 32'd16);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      check("clr_drops", 32'(drop_count), 32'd0);
      check("clr_flag", 32'(overflow), 32'd0);

      // Drain in order, with a two-cycle stall in the middle
      track_fifo_full = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i == 4) begin
            track_fifo_full = 1'b1;
            tick();
            check("stall_we0", 32'(track_fifo_we), 32'd0);
            tick();
            check("stall_we1", 32'(track_fifo_we), 32'd0);
            check("stall_hold", 32'(track_label), 32'h00103);
            track_fifo_full = 1'b0;
         end
         tick();
         expect_ev("drain", 20'h00100 + 20'(i), 1'b1);
      end
      tick();
      check("drain_done_we", 32'(track_fifo_we), 32'd0);
      check("drain_done_level", 32'(level), 32'd0);

      // Partial fit: one free slot takes the push, drops the pop; then drop wins over clear
      track_fifo_full = 1'b1;
      mon_we = 1'b1;
      for (int i = 0; i < 15; i++) begin
         mon_wr_data = 32'h00200 + 32'(i);
         tick();
      end
      mon_wr_data = 32'h0020F;
      mon_re = 1'b1; mon_rd_data = 32'h00CCC;
      tick();
      check("part_level", 32'(level), 32'd16);
      check("part_drops", 32'(drop_count), 32'd1);
      check("part_ovf", 32'(overflow), 32'd1);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0; mon_we = 1'b0; mon_re = 1'b0;
      check("clrdrop_drops", 32'(drop_count), 32'd2);
      check("clrdrop_ovf", 32'(overflow), 32'd1);
      track_fifo_full = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         expect_ev("part_drain", 20'h00200 + 20'(i), 1'b1);
      end
      tick();
      check("part_done_we", 32'(track_fifo_we), 32'd0);
      check("part_done_level", 32'(level), 32'd0);

      // Reset mid-stream discards queued events
      mon_we = 1'b1; mon_wr_data = 32'h00333;
      track_fifo_full = 1'b1;
      tick(); tick();
      mon_we = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0; track_fifo_full = 1'b0;
      check("mrst_level", 32'(level), 32'd0);
      check("mrst_drops", 32'(drop_count), 32'd0);
      check("mrst_ovf", 32'(overflow), 32'd0);
      tick();
      check("mrst_we", 32'(track_fifo_we), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
